keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the row lines. When a key is found, it locks onto that column and reports a one-hot `{row, col}` code and a level `key_pressed` flag. It sits directly upstream of the debouncer, which consumes `key_code` and `key_pressed` unchanged. Bounce filtering is the debouncer's job; this block only synchronizes the rows and holds the column while the key is down.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 3: cycles a column is driven before rows are sampled; covers synchronizer latency plus line settling; legal range 2..15.

Ports:
- `clk`  in  1  scanner clock.
- `reset`  in  1  reset, synchronous, active-low.
- `row_n`  in  4  raw keypad rows; asynchronous, externally pulled up; 0 means the key in the driven column is closed.
- `col_n`  out  4  column drive; one-hot active-low; exactly one bit is 0 at all times.
- `key_code`  out  8  `{row_onehot[3:0], col_onehot[3:0]}`, active-high; holds its last value after release.
- `key_pressed`  out  1  high while a key is held in the locked column.

## Operation
- `row_n` passes through a 2-FF synchronizer into `rows_s`; no other logic sees raw `row_n`.
- Internal state:
  - `col_idx` is 2 bits; `col_n = ~(4'b0001 << col_idx)`.
  - `settle_cnt` is 4 bits.
- State machine (`DRIVE`, `SAMPLE`, `HOLD`):
  - **`DRIVE`**: increment `settle_cnt` each cycle. When `settle_cnt == SETTLE_CYCLES-1`, clear it and go to `SAMPLE`.
  - **`SAMPLE`** with `rows_s == 4'b1111`: `col_idx <= col_idx+1` (3 wraps to 0), then go to `DRIVE`.
  - **`SAMPLE`** with any `rows_s` bit 0: select the lowest-index low row r. Load `key_code <= {1<<r, 1<<col_idx}`, set `key_pressed <= 1`, go to `HOLD`. `col_idx` is unchanged.
  - **`HOLD`**: keep driving the locked column. When `rows_s == 4'b1111`, clear `key_pressed`, advance `col_idx`, and go to `DRIVE`. Otherwise stay in `HOLD`.
  - Illegal state encodings go to `DRIVE` with `col_idx` 0.
- `key_code` changes only on the `SAMPLE`→`HOLD` transition.
  - Extra keys pressed during `HOLD`, in any row or column, are ignored until release.
  - Several low rows at `SAMPLE` report the lowest index only.

## Timing
- Reset values: state `DRIVE`, `col_idx` 0 (`col_n = 4'b1110`), `settle_cnt` 0, `key_code = 8'h00`, `key_pressed` 0, synchronizer flops 1.
- Reset asserted mid-`HOLD` takes effect at the next edge and overrides everything else; no partial-release behaviour.
- Idle column dwell is `SETTLE_CYCLES+1` cycles; a full idle scan takes `4*(SETTLE_CYCLES+1)` cycles (16 at default).
- Press latency: 2 cycles of synchronization plus the wait for the column's `SAMPLE`. Worst case is `2 + 4*(SETTLE_CYCLES+1)` cycles.
  - `key_code` and `key_pressed` update on the same edge, the one leaving `SAMPLE`.
- Release latency: `key_pressed` falls on the edge after `rows_s` reads all-ones in `HOLD`, which is 3 edges after `row_n` returns high.
  - The next column is driven from that same edge.
- A release-press glitch shorter than the synchronizer window may be missed; that is acceptable because the debouncer absorbs it.
- `col_n` and `key_code` come straight from registers, with no combinational path from `row_n`.

## Structure
- `keypad_pkg` holds:
  - `scan_state_t` enum (`DRIVE`, `SAMPLE`, `HOLD`);
  - `NUM_ROWS = 4`, `NUM_COLS = 4`;
  - `KEY_CODE_W = 8`;
  - `IDLE_COLS_N = 4'b1110`.
  The debouncer imports the same width constant.
- One sub-module: `sync2`, a parameterized-width 2-FF synchronizer with reset value 1, instantiated at width 4 for `row_n`.
- Scanner FSM, counter, and priority encoder live in `keypad_scanner`.

## Test plan
- **Reset/idle scan**: reset low for 2 cycles, then release with `row_n = 4'hF`.
  - Required: `col_n` cycles `1110 → 1101 → 1011 → 0111 → 1110`, each held 4 cycles; `key_pressed` stays 0; `key_code` stays `8'h00`.
- **Single press, row 2 / col 1**: model pulls `row_n[2]` low only while `col_n[1] = 0`.
  - Required: `key_code = 8'b0100_0010`, `key_pressed = 1`, `col_n` frozen at `1101` while the key is held.
  - After release: `key_pressed` falls exactly 3 edges after `row_n` returns high; `col_n` advances to `1011`.
- **Two keys in the same column, rows 1 and 3**: required `key_code = 8'b0010_xxxx`, i.e. row 1 wins.
- **Key held, second key in another column pressed then the first released**:
  - Required: no code change during `HOLD`.
  - After release, the scan resumes and reports the second key with a new `key_code`.
- **Reset mid-`HOLD`**: assert reset during a held key.
  - Required: next edge gives `col_n = 1110`, `key_pressed = 0`, `key_code = 8'h00`.
  - After reset deasserts with the key still down, the key is re-detected normally.
- **Worst-case latency**: key at col 0, pressed just after col 0's `SAMPLE` at `SETTLE_CYCLES = 3`.
  - Required: `key_pressed` rises no later than 18 cycles after the press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its downstream debouncer.
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 8;

  localparam logic [NUM_COLS-1:0] IDLE_COLS_N = 4'b1110;

  // Index of the lowest-numbered row reading low; rows must not be all-ones.
  function automatic logic [1:0] low_row_idx(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix lines plus the decoded key report handed to the debouncer.
interface keypad_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0]   row_n;
  logic [NUM_COLS-1:0]   col_n;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_pressed;

  modport master (input row_n, output col_n, output key_code, output key_pressed);
  modport slave  (output row_n, input col_n, input key_code, input key_pressed);

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer; flops reset to 1 to match idle pulled-up lines.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, locks on a pressed key and reports it.
//
//   state  | meaning
//   DRIVE  | column driven, waiting for rows to settle through the synchronizer
//   SAMPLE | rows examined once; either lock the key or move to the next column
//   HOLD   | key down, column frozen until every row reads high again
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  scan_state_t           state, state_nx;
  logic [1:0]            col_idx, col_idx_nx;
  logic [3:0]            settle_cnt, settle_cnt_nx;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_nx;
  logic                  key_pressed_q, key_pressed_nx;
  logic [NUM_ROWS-1:0]   rows_s;
  logic [2*NUM_COLS-1:0] col_rot;

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.row_n),
    .q     (rows_s)
  );

  // Rotating the idle pattern gives the one-hot-low column drive for col_idx.
  assign col_rot        = {IDLE_COLS_N, IDLE_COLS_N} << col_idx;
  assign kp.col_n       = col_rot[2*NUM_COLS-1:NUM_COLS];
  assign kp.key_code    = key_code_q;
  assign kp.key_pressed = key_pressed_q;

  // State, column, settle counter and key report registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= DRIVE;
      col_idx       <= 2'd0;
      settle_cnt    <= 4'd0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      state         <= state_nx;
      col_idx       <= col_idx_nx;
      settle_cnt    <= settle_cnt_nx;
      key_code_q    <= key_code_nx;
      key_pressed_q <= key_pressed_nx;
    end
  end

  // Next-state logic: settle, sample with lowest-row priority, hold until release.
  always_comb begin
    state_nx       = state;
    col_idx_nx     = col_idx;
    settle_cnt_nx  = settle_cnt;
    key_code_nx    = key_code_q;
    key_pressed_nx = key_pressed_q;
    case (state)
      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nx = 4'd0;
          state_nx      = SAMPLE;
        end else begin
          settle_cnt_nx = settle_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (rows_s == 4'b1111) begin
          col_idx_nx = col_idx + 2'd1;
          state_nx   = DRIVE;
        end else begin
          key_code_nx    = {4'b0001 << low_row_idx(rows_s), 4'b0001 << col_idx};
          key_pressed_nx = 1'b1;
          state_nx       = HOLD;
        end
      end
      HOLD: begin
        if (rows_s == 4'b1111) begin
          key_pressed_nx = 1'b0;
          col_idx_nx     = col_idx + 2'd1;
          state_nx       = DRIVE;
        end
      end
      default: begin
        state_nx      = DRIVE;
        col_idx_nx    = 2'd0;
        settle_cnt_nx = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: physical keypad model, directed scenarios and random presses,
// compared every cycle against a dwell-counting behavioural model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SETTLE = 3;

  logic        clk;
  logic        reset;
  logic [15:0] keys;   // bit r*4+c set = key at row r, column c is closed
  int          n_cmp;
  int          n_bad;

  keypad_if kp ();

  keypad_scanner #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    logic [3:0] rn;
    rn = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_n[c]) rn[r] = 1'b0;
    kp.row_n = rn;
  end

  // Reference model state
  bit         m_locked;
  int         m_col;
  int         m_dwell;
  logic [7:0] m_code;
  logic [3:0] m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] rn, input logic rs);
    logic [3:0] seen;
    int         r;
    if (!rs) begin
      m_locked = 0; m_col = 0; m_dwell = 0; m_code = 8'h00;
      m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = rn;
      if (!m_locked) begin
        if (m_dwell == SETTLE) begin
          if (seen != 4'hF) begin
            r = 0;
            while (seen[r]) r++;
            m_code = 8'h00;
            m_code[4+r] = 1'b1;
            m_code[m_col] = 1'b1;
            m_locked = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
          m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end else if (seen == 4'hF) begin
        m_locked = 0;
        m_col = (m_col + 1) % 4;
        m_dwell = 0;
      end
    end
  endtask

  // One clock: capture inputs before the edge, advance model, compare at negedge.
  task automatic step();
    logic [3:0] rn;
    logic       rs;
    logic [3:0] exp_col;
    #1;
    rn = kp.row_n;
    rs = reset;
    @(posedge clk);
    model_step(rn, rs);
    @(negedge clk);
    exp_col = ~(4'b0001 << m_col);
    chk("m_col_n", kp.col_n, exp_col);
    chk("m_key_code", kp.key_code, m_code);
    chk("m_key_pressed", kp.key_pressed, m_locked);
    chk("col_onehot", $countones(~kp.col_n), 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pressed(input logic val, input int max, output int n);
    n = 0;
    while (kp.key_pressed !== val && n < max) begin
      step();
      n++;
    end
    chk("wait_pressed", kp.key_pressed, val);
  endtask

  task automatic wait_col(input logic [3:0] col, input int max);
    int n;
    n = 0;
    while (kp.col_n !== col && n < max) begin
      step();
      n++;
    end
    chk("wait_col", kp.col_n, col);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] exp_col;
    n_cmp = 0;
    n_bad = 0;
    keys  = 16'h0;
    reset = 1'b0;
    m_locked = 0; m_col = 0; m_dwell = 0; m_code = 8'h00;
    m_s1 = 4'hF; m_s2 = 4'hF;
    @(negedge clk);

    // Reset and idle scan
    steps(2);
    chk("rst_col_n", kp.col_n, 4'b1110);
    chk("rst_key_code", kp.key_code, 8'h00);
    chk("rst_pressed", kp.key_pressed, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      chk("idle_col_n", kp.col_n, exp_col);
      chk("idle_code", kp.key_code, 8'h00);
      chk("idle_pressed", kp.key_pressed, 1'b0);
    end

    // Single press row 2 / col 1, then release latency
    keys = 16'h0001 << (2*4 + 1);
    wait_pressed(1'b1, 30, n);
    chk("single_code", kp.key_code, 8'b0100_0010);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("single_hold_col", kp.col_n, 4'b1101);
    end
    keys = 16'h0;
    wait_pressed(1'b0, 10, n);
    chk("release_latency", n, 3);
    chk("release_next_col", kp.col_n, 4'b1011);
    steps(6);

    // Two keys in column 2, rows 1 and 3: row 1 wins
    keys = (16'h0001 << (1*4 + 2)) | (16'h0001 << (3*4 + 2));
    wait_pressed(1'b1, 30, n);
    chk("two_rows_code", kp.key_code, 8'b0010_0100);
    keys = 16'h0;
    wait_pressed(1'b0, 10, n);
    steps(5);

    // Held key at (0,0), second key at (3,2) ignored until release
    keys = 16'h0001;
    wait_pressed(1'b1, 30, n);
    chk("first_code", kp.key_code, 8'b0001_0001);
    keys = keys | (16'h0001 << (3*4 + 2));
    for (int k = 0; k < 12; k++) begin
      step();
      chk("hold_code_fixed", kp.key_code, 8'b0001_0001);
      chk("hold_col_fixed", kp.col_n, 4'b1110);
    end
    keys = 16'h0001 << (3*4 + 2);
    wait_pressed(1'b0, 10, n);
    wait_pressed(1'b1, 30, n);
    chk("second_code", kp.key_code, 8'b1000_0100);
    keys = 16'h0;
    wait_pressed(1'b0, 10, n);
    steps(3);

    // Reset mid-HOLD with key (1,3) still down, then re-detection
    keys = 16'h0001 << (1*4 + 3);
    wait_pressed(1'b1, 30, n);
    steps(2);
    reset = 1'b0;
    step();
    chk("midrst_col_n", kp.col_n, 4'b1110);
    chk("midrst_pressed", kp.key_pressed, 1'b0);
    chk("midrst_code", kp.key_code, 8'h00);
    reset = 1'b1;
    wait_pressed(1'b1, 30, n);
    chk("redetect_code", kp.key_code, 8'b0010_1000);
    keys = 16'h0;
    wait_pressed(1'b0, 10, n);

    // Worst-case latency: press col 0 key just after col 0 has been sampled
    wait_col(4'b1110, 20);
    wait_col(4'b1101, 20);
    keys = 16'h0001 << (3*4 + 0);
    wait_pressed(1'b1, 30, n);
    chk("worst_latency_le18", (n <= 2 + 4*(SETTLE+1)), 1'b1);
    chk("worst_code", kp.key_code, 8'b1000_0001);
    keys = 16'h0;
    wait_pressed(1'b0, 10, n);

    // Random presses, glitches and occasional reset pulses against the model
    for (int ep = 0; ep < 30; ep++) begin
      keys = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) keys = keys | (16'h0001 << $urandom_range(0, 15));
      steps($urandom_range(1, 40));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      keys = 16'h0;
      steps($urandom_range(0, 25));
    end
    steps(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
